wb_dma_ch_arb: RTL and testbench
================================

Name: wb_dma_ch_arb

Overview:
- Channel arbiter/scheduler for the wb_dma channel-select path.
- Picks one requesting channel by priority level, with round-robin among equal priorities.
- Presents the choice as ch_sel/valid_sel/pri_out and pulses de_start to the DMA engine.
- Holds the selection locked until the engine signals transfer completion; sits between the channel register file and the DMA engine.

Parameters:
- CH_COUNT, 8, number of channels arbitrated (1..31).
- PRI_LEVELS, 8, priority levels in use (1, 2, 4 or 8); channel priority is masked to log2(PRI_LEVELS) LSBs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ch_valid  in  CH_COUNT  channel enabled and requesting service.
- ch_pri  in  3*CH_COUNT  packed per-channel priority; channel i at bits [3i+2:3i].
- dma_busy  in  1  engine is executing a transfer.
- dma_done  in  1  one-cycle pulse, transfer finished.
- ch_sel  out  5  selected channel index.
- valid_sel  out  1  ch_sel holds a live grant.
- pri_out  out  3  masked priority of the granted channel.
- de_start  out  1  one-cycle start pulse to the engine.
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - ch_sel=0, valid_sel=0, pri_out=0, de_start=0, arb_busy=0, state=IDLE.
  - Per-level round-robin pointers rr_ptr[0..PRI_LEVELS-1]=CH_COUNT-1, so channel 0 wins first.
- Reset mid-operation: all outputs take reset values on the next edge; the in-flight grant is abandoned and pointers are reset.
- Effective priority: ep[i] = ch_pri[i] & (PRI_LEVELS-1). Higher value wins.
- Pick rule:
  - top = max ep over channels with ch_valid set.
  - Among valid channels with ep==top, grant the first index strictly greater than rr_ptr[top], searching upward and wrapping from CH_COUNT-1 to 0.
  - If only rr_ptr[top] itself is valid, grant it.
- States:
  - IDLE: if |ch_valid, register ch_sel, pri_out=top, valid_sel=1, and go to START. Otherwise hold; ch_sel and pri_out keep their last values.
  - START: de_start=1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: dma_busy=1 -> RUN. dma_done=1 (with or without busy) -> completion.
  - RUN: dma_done=1 -> completion. Otherwise hold.
  - Completion: rr_ptr[pri_out]=ch_sel, valid_sel=0, go to IDLE.
- Latency: a request sampled in IDLE at edge N gives ch_sel/valid_sel/de_start valid in cycle N+1.
- Lock: from START until completion, ch_sel and pri_out are frozen. Changes to ch_valid or ch_pri (including the granted channel dropping, or a higher priority arriving) are ignored.
- Committed grant: if the granted channel's ch_valid drops in the START cycle, de_start still fires.
- dma_done coincident with a new request in RUN: go to IDLE. The new arbitration happens on the following edge, so there is a minimum one IDLE cycle between grants.
- dma_done outside WAIT_BUSY/RUN is ignored. dma_busy in IDLE/START is ignored.
- ch_sel never exceeds CH_COUNT-1. Unused upper bits of the 5-bit field are zero.

Decomposition:
- Package wb_dma_arb_pkg:
  - state enum {IDLE, START, WAIT_BUSY, RUN}.
  - Constants MAX_CH=31, CH_W=5, PRI_W=3.
  - Function for priority masking.
- Sub-module wb_dma_rr_pick (combinational): inputs are a CH_COUNT request mask and pointer; outputs are a found flag and the index of the first set bit after the pointer, with wrap.
- The top level instantiates one wb_dma_rr_pick, fed with the mask of valid channels at level top.

Test Plan:
1. After reset, ch_valid[3]=1, ch_pri[3]=2 -> next cycle ch_sel=3, pri_out=2, valid_sel=1, de_start high one cycle. Then dma_busy=1 followed by dma_done pulse -> valid_sel=0 next cycle, arb_busy=0.
2. Priority: ch1 pri=1 and ch5 pri=6, both valid -> ch_sel=5. After its completion, with ch5 dropped -> ch_sel=1.
3. Round-robin: ch0, ch2, ch4 all pri=3, held valid; each grant completed -> grant order 0, 2, 4, 0.
4. Lock: in RUN with ch_sel=2, drop ch_valid[2] and raise ch7 pri=7 -> ch_sel stays 2, no de_start until dma_done. Next grant is 7.
5. PRI_LEVELS=2: ch1 pri=6 (masks to 0), ch2 pri=1 -> ch_sel=2, pri_out=1.
6. Reset in RUN with ch_sel=4 -> next cycle all outputs 0, state IDLE. With ch0 and ch4 both valid at equal priority afterwards -> ch_sel=0.

Source files
------------

// File: rtl/wb_dma_arb_pkg.sv
// Shared types and helpers for the wb_dma channel arbiter.
//   arb_state_e : arbiter FSM states
//   MAX_CH      : largest supported channel count
//   CH_W/PRI_W  : widths of the channel index and priority fields
//   mask_pri    : reduces a raw 3-bit priority to the levels in use
package wb_dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    RUN       = 2'd3
  } arb_state_e;

  localparam int MAX_CH = 31;
  localparam int CH_W   = 5;
  localparam int PRI_W  = 3;

  // Keep only the priority bits that are meaningful for the configured
  // number of levels (levels is a power of two, 1..8).
  function automatic logic [PRI_W-1:0] mask_pri(input logic [PRI_W-1:0] pri,
                                                 input int levels);
    return pri & PRI_W'(levels - 1);
  endfunction

endpackage

// File: rtl/wb_dma_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request mask, one bit per channel
//   ptr_i   : index of the most recently served channel
//   found_o : at least one request bit is set
//   idx_o   : first set bit strictly after ptr_i, wrapping; ptr_i itself
//             is chosen only when it is the sole request
module wb_dma_rr_pick
  import wb_dma_arb_pkg::*;
#(
  parameter int CH_COUNT = 8
) (
  input  logic [CH_COUNT-1:0] req_i,
  input  logic [CH_W-1:0]     ptr_i,
  output logic                found_o,
  output logic [CH_W-1:0]     idx_o
);

  int best_d;
  int d;

  // Each channel's distance after the pointer: ptr+1 -> 0, ptr -> CH_COUNT-1.
  // The smallest distance among requesters wins.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    best_d  = CH_COUNT;
    d       = 0;
    for (int i = 0; i < CH_COUNT; i++) begin
      d = (i + CH_COUNT - int'(ptr_i) - 1) % CH_COUNT;
      if (req_i[i] && (d < best_d)) begin
        best_d = d;
        idx_o  = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_dma_ch_arb.sv
// Channel arbiter for the wb_dma channel-select path.
// Picks the highest effective priority among requesting channels, with
// round-robin among equal priorities, then holds that grant until the
// DMA engine reports completion.
//   clk, rst  : clock, synchronous active-high reset
//   ch_valid  : per-channel request
//   ch_pri    : packed per-channel priority, channel i at [3i+2:3i]
//   dma_busy  : engine executing a transfer
//   dma_done  : one-cycle transfer-finished pulse
//   ch_sel    : granted channel index
//   valid_sel : ch_sel holds a live grant
//   pri_out   : masked priority of the granted channel
//   de_start  : one-cycle start pulse to the engine
//   arb_busy  : arbiter is not idle
module wb_dma_ch_arb
  import wb_dma_arb_pkg::*;
#(
  parameter int CH_COUNT   = 8,
  parameter int PRI_LEVELS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_COUNT-1:0]       ch_valid,
  input  logic [PRI_W*CH_COUNT-1:0] ch_pri,
  input  logic                      dma_busy,
  input  logic                      dma_done,
  output logic [CH_W-1:0]           ch_sel,
  output logic                      valid_sel,
  output logic [PRI_W-1:0]          pri_out,
  output logic                      de_start,
  output logic                      arb_busy
);

  arb_state_e          state_q;
  logic [CH_W-1:0]     ch_sel_q;
  logic                valid_sel_q;
  logic [PRI_W-1:0]    pri_q;
  logic                de_start_q;
  // Sized for the maximum of 8 levels; only [0..PRI_LEVELS-1] are reachable.
  logic [CH_W-1:0]     rr_ptr_q [8];

  logic [PRI_W-1:0]    ep [CH_COUNT];
  logic [PRI_W-1:0]    top;
  logic [CH_COUNT-1:0] lvl_req;
  logic [CH_W-1:0]     cur_ptr;
  logic                pick_found;
  logic [CH_W-1:0]     pick_idx;

  // Highest effective priority among requesters, then the set of
  // requesters at exactly that level.
  always_comb begin
    top     = '0;
    lvl_req = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      ep[i] = mask_pri(ch_pri[PRI_W*i +: PRI_W], PRI_LEVELS);
    end
    for (int i = 0; i < CH_COUNT; i++) begin
      if (ch_valid[i] && (ep[i] > top)) top = ep[i];
    end
    for (int i = 0; i < CH_COUNT; i++) begin
      lvl_req[i] = ch_valid[i] && (ep[i] == top);
    end
  end

  assign cur_ptr = rr_ptr_q[top];

  wb_dma_rr_pick #(
    .CH_COUNT (CH_COUNT)
  ) u_pick (
    .req_i   (lvl_req),
    .ptr_i   (cur_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_sel_q    <= '0;
      valid_sel_q <= 1'b0;
      pri_q       <= '0;
      de_start_q  <= 1'b0;
      for (int p = 0; p < 8; p++) rr_ptr_q[p] <= CH_W'(CH_COUNT - 1);
    end else begin
      de_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Raising de_start here makes it coincide with the START cycle.
          if (pick_found) begin
            ch_sel_q    <= pick_idx;
            pri_q       <= top;
            valid_sel_q <= 1'b1;
            de_start_q  <= 1'b1;
            state_q     <= START;
          end
        end
        START: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          // A transfer can finish before busy is ever observed.
          if (dma_done) begin
            rr_ptr_q[pri_q] <= ch_sel_q;
            valid_sel_q     <= 1'b0;
            state_q         <= IDLE;
          end else if (dma_busy) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (dma_done) begin
            rr_ptr_q[pri_q] <= ch_sel_q;
            valid_sel_q     <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_sel    = ch_sel_q;
  assign valid_sel = valid_sel_q;
  assign pri_out   = pri_q;
  assign de_start  = de_start_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_dma_ch_arb.sv
module tb_wb_dma_ch_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ch_valid;
  logic [23:0] ch_pri;
  logic        dma_busy;
  logic        dma_done;
  logic [4:0]  ch_sel;
  logic        valid_sel;
  logic [2:0]  pri_out;
  logic        de_start;
  logic        arb_busy;

  // Second instance with two priority levels
  logic [7:0]  ch_valid2;
  logic [23:0] ch_pri2;
  logic        zero_busy2 = 1'b0;
  logic        zero_done2 = 1'b0;
  logic [4:0]  ch_sel2;
  logic        valid_sel2;
  logic [2:0]  pri_out2;
  logic        de_start2;
  logic        arb_busy2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_dma_ch_arb #(.CH_COUNT(8), .PRI_LEVELS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_pri    (ch_pri),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done),
    .ch_sel    (ch_sel),
    .valid_sel (valid_sel),
    .pri_out   (pri_out),
    .de_start  (de_start),
    .arb_busy  (arb_busy)
  );

  wb_dma_ch_arb #(.CH_COUNT(8), .PRI_LEVELS(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid2),
    .ch_pri    (ch_pri2),
    .dma_busy  (zero_busy2),
    .dma_done  (zero_done2),
    .ch_sel    (ch_sel2),
    .valid_sel (valid_sel2),
    .pri_out   (pri_out2),
    .de_start  (de_start2),
    .arb_busy  (arb_busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pri(input int ch, input logic [2:0] p);
    ch_pri[3*ch +: 3] = p;
  endtask

  // Called in the START cycle; returns sampled in the following IDLE cycle.
  task automatic finish_xfer(input bit use_busy);
    tick();                       // WAIT_BUSY
    if (use_busy) begin
      dma_busy = 1'b1;
      tick();                     // RUN
    end
    dma_done = 1'b1;
    tick();                       // IDLE
    dma_done = 1'b0;
    dma_busy = 1'b0;
  endtask

  initial begin
    int exp_rr [4];
    exp_rr = '{0, 2, 4, 0};

    rst = 1'b1; ch_valid = '0; ch_pri = '0; dma_busy = 1'b0; dma_done = 1'b0;
    ch_valid2 = '0; ch_pri2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ch_sel",    ch_sel,    0);
    check("rst_valid_sel", valid_sel, 0);
    check("rst_pri_out",   pri_out,   0);
    check("rst_de_start",  de_start,  0);
    check("rst_arb_busy",  arb_busy,  0);

    // Two-level instance: ch1 pri 6 masks to 0, ch2 pri 1 stays 1
    ch_valid2 = 8'b0000_0110;
    ch_pri2[3*1 +: 3] = 3'd6;
    ch_pri2[3*2 +: 3] = 3'd1;

    // Basic grant of ch3 at priority 2
    ch_valid = 8'b0000_1000;
    set_pri(3, 3'd2);
    tick();
    check("t1_ch_sel",    ch_sel,    3);
    check("t1_pri_out",   pri_out,   2);
    check("t1_valid_sel", valid_sel, 1);
    check("t1_de_start",  de_start,  1);
    check("t1_arb_busy",  arb_busy,  1);
    check("t5_ch_sel",    ch_sel2,   2);
    check("t5_pri_out",   pri_out2,  1);
    ch_valid = '0;
    tick();
    check("t1_de_start_once", de_start, 0);
    dma_busy = 1'b1;
    tick();
    check("t1_run_valid", valid_sel, 1);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0; dma_busy = 1'b0;
    check("t1_done_valid", valid_sel, 0);
    check("t1_done_busy",  arb_busy,  0);

    // dma_done in IDLE is ignored
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("idle_done_busy", arb_busy, 0);

    // Priority: ch5 (6) beats ch1 (1); ch5 drops in START yet still runs
    ch_pri = '0;
    set_pri(1, 3'd1);
    set_pri(5, 3'd6);
    ch_valid = 8'b0010_0010;
    tick();
    check("t2_hi_ch_sel",  ch_sel,   5);
    check("t2_hi_pri",     pri_out,  6);
    check("t2_hi_start",   de_start, 1);
    ch_valid = 8'b0000_0010;
    finish_xfer(1'b1);
    check("t2_idle_gap", valid_sel, 0);
    tick();
    check("t2_lo_ch_sel", ch_sel,  1);
    check("t2_lo_pri",    pri_out, 1);
    ch_valid = '0;
    // Completion straight from WAIT_BUSY without busy
    finish_xfer(1'b0);
    check("t2_done_nobusy", arb_busy, 0);

    // Round-robin among ch0, ch2, ch4 at priority 3
    ch_pri = '0;
    set_pri(0, 3'd3);
    set_pri(2, 3'd3);
    set_pri(4, 3'd3);
    ch_valid = 8'b0001_0101;
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("t3_rr%0d", g), ch_sel, exp_rr[g]);
      finish_xfer(1'b1);
      check($sformatf("t3_gap%0d", g), valid_sel, 0);
    end
    ch_valid = '0;
    tick();

    // Lock: grant ch2, then drop it and raise ch7 at priority 7 during RUN
    ch_pri = '0;
    ch_valid = 8'b0000_0100;
    tick();
    check("t4_ch_sel", ch_sel, 2);
    tick();
    dma_busy = 1'b1;
    tick();
    ch_valid = 8'b1000_0000;
    set_pri(7, 3'd7);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t4_lock_sel%0d", c), ch_sel,   2);
      check($sformatf("t4_lock_pri%0d", c), pri_out,  0);
      check($sformatf("t4_lock_ds%0d", c),  de_start, 0);
    end
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0; dma_busy = 1'b0;
    check("t4_done_valid", valid_sel, 0);
    tick();
    check("t4_next_sel", ch_sel,  7);
    check("t4_next_pri", pri_out, 7);
    ch_valid = '0;
    finish_xfer(1'b1);

    // Reset while running ch4, then pointer must restart at channel 0
    ch_pri = '0;
    set_pri(4, 3'd5);
    ch_valid = 8'b0001_0000;
    tick();
    check("t6_ch_sel", ch_sel, 4);
    tick();
    dma_busy = 1'b1;
    tick();
    check("t6_running", arb_busy, 1);
    rst = 1'b1;
    ch_valid = '0;
    tick();
    rst = 1'b0; dma_busy = 1'b0;
    check("t6_rst_ch_sel",   ch_sel,    0);
    check("t6_rst_valid",    valid_sel, 0);
    check("t6_rst_pri",      pri_out,   0);
    check("t6_rst_de_start", de_start,  0);
    check("t6_rst_arb_busy", arb_busy,  0);
    ch_pri = '0;
    set_pri(0, 3'd3);
    set_pri(4, 3'd3);
    ch_valid = 8'b0001_0001;
    tick();
    check("t6_after_rst_sel", ch_sel, 0);
    check("t6_after_rst_pri", pri_out, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
